hdmi_clock_reset_ctrl: RTL

//  Sequencer on the input reference clock. Consumes the HDMI PLL lock and drives the /5 divider's RESETN/CALIB.

---
 rtl/hdmi_clock_reset_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hdmi_clock_reset_ctrl.sv
// HDMI clock/reset sequencer: qualifies PLL lock, releases the /5 divider, pulses CALIB, then releases the pixel reset.
// Optional PLL retry on lock timeout is enabled by defining HDMI_CLK_RETRY_EN.
module hdmi_clock_reset_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DIV_SETTLE_CYCLES  = 16,
  parameter int CALIB_CYCLES       = 4,
  parameter int RUN_DELAY_CYCLES   = 64,
  parameter int LOCK_TIMEOUT       = 1 << 20,
  parameter int PLL_RESET_CYCLES   = 32,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hdmi_clk_lock,
  output logic             clkdiv_resetn,
  output logic             clkdiv_calib,
  output logic             pll_reset,
  output logic             hdmi_rst_n,
  output logic             clocks_ready,
  output logic [CNT_W-1:0] lock_loss_count
);

  // One shared timer, sized for the longest interval any state may need.
  localparam int TMAX_A  = (LOCK_STABLE_CYCLES > DIV_SETTLE_CYCLES) ? LOCK_STABLE_CYCLES : DIV_SETTLE_CYCLES;
  localparam int TMAX_B  = (CALIB_CYCLES > RUN_DELAY_CYCLES) ? CALIB_CYCLES : RUN_DELAY_CYCLES;
  localparam int TMAX_C  = (LOCK_TIMEOUT > PLL_RESET_CYCLES) ? LOCK_TIMEOUT : PLL_RESET_CYCLES;
  localparam int TMAX_AB = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TMAX    = (TMAX_AB > TMAX_C) ? TMAX_AB : TMAX_C;
  localparam int TIMER_W = $clog2(TMAX) + 1;

  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(DIV_SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CALIB_LAST  = TIMER_W'(CALIB_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RUN_LAST    = TIMER_W'(RUN_DELAY_CYCLES - 1);
`ifdef HDMI_CLK_RETRY_EN
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] PLL_LAST     = TIMER_W'(PLL_RESET_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    DIV_REL     = 3'd2,
    CALIB       = 3'd3,
    SETTLE      = 3'd4,
    RUN         = 3'd5
`ifdef HDMI_CLK_RETRY_EN
    ,
    PLL_RST     = 3'd6
`endif
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [TIMER_W-1:0] timer;
  logic               sync1;
  logic               lock_s;

  always_comb begin
    next_state = state;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) next_state = LOCK_STABLE;
`ifdef HDMI_CLK_RETRY_EN
        else if (timer == TIMEOUT_LAST) next_state = PLL_RST;
`endif
      end
      LOCK_STABLE: begin
        if (!lock_s) next_state = WAIT_LOCK;
        else if (timer == STABLE_LAST) next_state = DIV_REL;
      end
      DIV_REL: begin
        if (!lock_s) next_state = WAIT_LOCK;
        else if (timer == SETTLE_LAST) next_state = CALIB;
      end
      CALIB: begin
        if (!lock_s) next_state = WAIT_LOCK;
        else if (timer == CALIB_LAST) next_state = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) next_state = WAIT_LOCK;
        else if (timer == RUN_LAST) next_state = RUN;
      end
      RUN: begin
        if (!lock_s) next_state = WAIT_LOCK;
      end
`ifdef HDMI_CLK_RETRY_EN
      // Lock is deliberately ignored while the PLL is being reset.
      PLL_RST: begin
        if (timer == PLL_LAST) next_state = WAIT_LOCK;
      end
`endif
      default: next_state = WAIT_LOCK;
    endcase
  end

  // Outputs decode next_state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1           <= 1'b0;
      lock_s          <= 1'b0;
      state           <= WAIT_LOCK;
      timer           <= '0;
      clkdiv_resetn   <= 1'b0;
      clkdiv_calib    <= 1'b0;
      hdmi_rst_n      <= 1'b0;
      clocks_ready    <= 1'b0;
      lock_loss_count <= '0;
`ifdef HDMI_CLK_RETRY_EN
      pll_reset       <= 1'b0;
`endif
    end else begin
      sync1         <= hdmi_clk_lock;
      lock_s        <= sync1;
      state         <= next_state;
      timer         <= (next_state != state) ? '0 : timer + 1'b1;
      clkdiv_resetn <= (next_state == DIV_REL) || (next_state == CALIB) ||
                       (next_state == SETTLE) || (next_state == RUN);
      clkdiv_calib  <= (next_state == CALIB);
      hdmi_rst_n    <= (next_state == RUN);
      clocks_ready  <= (next_state == RUN);
`ifdef HDMI_CLK_RETRY_EN
      pll_reset     <= (next_state == PLL_RST);
`endif
      if ((state == RUN) && (next_state == WAIT_LOCK) && (lock_loss_count != '1))
        lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

`ifndef HDMI_CLK_RETRY_EN
  assign pll_reset = 1'b0;
`endif

endmodule
